// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and drives mux selects, write strobes and ALUOp. Define CTRL_ADDI_EN to add the ADDI instruction.
module multicycle_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
`ifdef CTRL_ADDI_EN
    ,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  // Ungated strobe decodes; the reset gate is applied at the output boundary.
  logic pcwrite_c;
  logic branch_c;
  logic irwrite_c;
  logic regwrite_c;
  logic memwrite_c;
  logic illegal_c;
  logic done_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    illegal_c  = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        irwrite_c = MemReady;
        pcwrite_c = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        ALUSrcB = 2'b11;
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEMADR;
        else if (Opcode == OP_RTYPE)            state_d = S_EXECUTE;
        else if (Opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (Opcode == OP_J)                state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
        else if (Opcode == OP_ADDI)             state_d = S_ADDIEX;
`endif
        else begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write strobe stays up through every stall cycle until memory accepts it.
        IorD       = 1'b1;
        memwrite_c = 1'b1;
        done_c     = MemReady;
        state_d    = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        branch_c = 1'b1;
        done_c   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        pcwrite_c = 1'b1;
        done_c    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef CTRL_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // FETCH decodes its strobes from MemReady, so reset must mask them combinationally.
  assign IRWrite   = irwrite_c  & ~reset;
  assign PCEn      = (pcwrite_c | (branch_c & Zero)) & ~reset;
  assign RegWrite  = regwrite_c & ~reset;
  assign MemWrite  = memwrite_c & ~reset;
  assign IllegalOp = illegal_c  & ~reset;
  assign InstrDone = done_c     & ~reset;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector bench for multicycle_control_fsm: a table of per-cycle inputs and expected outputs,
// plus hand-written ADDI and mid-instruction reset sequences.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // Output word: {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
  //               ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], PCEn, IllegalOp, InstrDone}
  localparam logic [15:0] E_FETCH_RDY = 16'h2084;
  localparam logic [15:0] E_FETCH_STL = 16'h0080;
  localparam logic [15:0] E_DECODE    = 16'h0180;
  localparam logic [15:0] E_ILLEGAL   = 16'h0182;
  localparam logic [15:0] E_MEMADR    = 16'h0300;
  localparam logic [15:0] E_MEMREAD   = 16'h8000;
  localparam logic [15:0] E_MEMWB     = 16'h0C01;
  localparam logic [15:0] E_MEMWR_STL = 16'hC000;
  localparam logic [15:0] E_MEMWR_RDY = 16'hC001;
  localparam logic [15:0] E_EXECUTE   = 16'h0240;
  localparam logic [15:0] E_ALUWB     = 16'h1401;
  localparam logic [15:0] E_BRANCH_T  = 16'h022D;
  localparam logic [15:0] E_BRANCH_NT = 16'h0229;
  localparam logic [15:0] E_JUMP      = 16'h0015;
  localparam logic [15:0] E_ADDIEX    = 16'h0300;
  localparam logic [15:0] E_ADDIWB    = 16'h0401;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       memready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegalop, instrdone;
  logic [15:0] got;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (opcode),
    .Zero      (zero),
    .MemReady  (memready),
    .IorD      (iord),
    .MemWrite  (memwrite),
    .IRWrite   (irwrite),
    .RegDst    (regdst),
    .MemtoReg  (memtoreg),
    .RegWrite  (regwrite),
    .ALUSrcA   (alusrca),
    .ALUSrcB   (alusrcb),
    .ALUOp     (aluop),
    .PCSrc     (pcsrc),
    .PCEn      (pcen),
    .IllegalOp (illegalop),
    .InstrDone (instrdone)
  );

  assign got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, pcen, illegalop, instrdone};

  task automatic check(input string name, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %04h expected %04h", name, got, exp);
    end
  endtask

  // One cycle: drive inputs on the falling edge, compare just after, the rising edge advances state.
  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                      input logic [15:0] exp, input string name);
    @(negedge clk);
    reset    = r;
    opcode   = op;
    zero     = z;
    memready = mr;
    #1;
    check(name, exp);
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input logic [15:0] exp);
    vecs.push_back('{rst: r, op: op, z: z, mr: mr, exp: exp});
  endtask

  initial begin
    reset    = 1'b1;
    opcode   = OP_RTYPE;
    zero     = 1'b0;
    memready = 1'b1;

    // Reset held with MemReady high, then release into FETCH.
    add(1, OP_RTYPE, 0, 1, E_FETCH_STL);
    add(1, OP_RTYPE, 0, 1, E_FETCH_STL);
    add(0, OP_RTYPE, 0, 1, E_FETCH_RDY);
    // R-type: 4 cycles.
    add(0, OP_RTYPE, 0, 1, E_DECODE);
    add(0, OP_RTYPE, 0, 1, E_EXECUTE);
    add(0, OP_RTYPE, 0, 1, E_ALUWB);
    // LW with 3 stall cycles in MEMREAD: 8 cycles.
    add(0, OP_LW, 0, 1, E_FETCH_RDY);
    add(0, OP_LW, 0, 1, E_DECODE);
    add(0, OP_LW, 0, 1, E_MEMADR);
    add(0, OP_LW, 0, 0, E_MEMREAD);
    add(0, OP_LW, 0, 0, E_MEMREAD);
    add(0, OP_LW, 0, 0, E_MEMREAD);
    add(0, OP_LW, 0, 1, E_MEMREAD);
    add(0, OP_LW, 0, 1, E_MEMWB);
    // Fetch stall, then SW with 2 stall cycles.
    add(0, OP_SW, 0, 0, E_FETCH_STL);
    add(0, OP_SW, 0, 1, E_FETCH_RDY);
    add(0, OP_SW, 0, 1, E_DECODE);
    add(0, OP_SW, 0, 1, E_MEMADR);
    add(0, OP_SW, 0, 0, E_MEMWR_STL);
    add(0, OP_SW, 0, 0, E_MEMWR_STL);
    add(0, OP_SW, 0, 1, E_MEMWR_RDY);
    // BEQ taken, BEQ not taken.
    add(0, OP_BEQ, 1, 1, E_FETCH_RDY);
    add(0, OP_BEQ, 1, 1, E_DECODE);
    add(0, OP_BEQ, 1, 1, E_BRANCH_T);
    add(0, OP_BEQ, 0, 1, E_FETCH_RDY);
    add(0, OP_BEQ, 0, 1, E_DECODE);
    add(0, OP_BEQ, 0, 1, E_BRANCH_NT);
    // Jump.
    add(0, OP_J, 0, 1, E_FETCH_RDY);
    add(0, OP_J, 0, 1, E_DECODE);
    add(0, OP_J, 0, 1, E_JUMP);
    // Unsupported opcode returns straight to FETCH.
    add(0, OP_BAD, 0, 1, E_FETCH_RDY);
    add(0, OP_BAD, 0, 1, E_ILLEGAL);
    add(0, OP_ADDI, 0, 1, E_FETCH_RDY);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // ADDI: a 4-cycle instruction when enabled, otherwise illegal.
`ifdef CTRL_ADDI_EN
    step(0, OP_ADDI, 0, 1, E_DECODE,    "addi_decode");
    step(0, OP_ADDI, 0, 1, E_ADDIEX,    "addi_ex");
    step(0, OP_ADDI, 0, 1, E_ADDIWB,    "addi_wb");
    step(0, OP_SW,   0, 1, E_FETCH_RDY, "addi_fetch");
`else
    step(0, OP_ADDI, 0, 1, E_ILLEGAL,   "addi_illegal");
    step(0, OP_SW,   0, 1, E_FETCH_RDY, "addi_fetch");
`endif

    // Reset asserted mid-store: strobes drop at once and the FSM restarts at FETCH.
    step(0, OP_SW, 0, 1, E_DECODE,    "rst_seq_decode");
    step(0, OP_SW, 0, 1, E_MEMADR,    "rst_seq_memadr");
    step(0, OP_SW, 0, 0, E_MEMWR_STL, "rst_seq_memwr");
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_strobes", E_FETCH_STL);
    memready = 1'b1;
    #1;
    check("rst_mid_memready", E_FETCH_STL);
    step(1, OP_SW, 0, 1, E_FETCH_STL, "rst_held");
    step(0, OP_SW, 0, 1, E_FETCH_RDY, "rst_release");
    step(0, OP_SW, 0, 1, E_DECODE,    "rst_restart_decode");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
